// File: rtl/player_move_ctrl.sv
// player_move_ctrl: steps the player through the maze one cell per movement
// tick. It probes the leading edge of the 4x4 footprint against the wall map,
// one cell per cycle, then commits or rejects the move.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for move_tick with a direction held
// CHECK   | probing leading-edge cell k (q_en high), abort on wall_hit
// COMMIT  | apply candidate (moved/goal) or hold position (bumped)
module player_move_ctrl #(
  parameter int MAP_W   = 40,
  parameter int P_SIZE  = 4,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int GOAL_X  = 35,
  parameter int GOAL_Y  = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       move_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       q_en,
  output logic [5:0] q_col,
  output logic [5:0] q_row,
  input  logic       wall_hit,
  output logic [5:0] player_x,
  output logic [5:0] player_y,
  output logic       busy,
  output logic       moved,
  output logic       bumped,
  output logic       goal
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_DOWN  = 2'd1;
  localparam logic [1:0] D_LEFT  = 2'd2;
  localparam logic [1:0] D_RIGHT = 2'd3;

  localparam logic signed [6:0] POS_MAX = 7'(MAP_W - P_SIZE);
  localparam logic [1:0]        K_LAST  = 2'(P_SIZE - 1);

  logic [1:0] fsm_q, fsm_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] k_q, k_d;
  logic       blocked_q, blocked_d;
  logic [5:0] cand_x_q, cand_x_d;
  logic [5:0] cand_y_q, cand_y_d;
  logic [5:0] px_q, px_d;
  logic [5:0] py_q, py_d;
  logic [5:0] q_col_q, q_col_d;
  logic [5:0] q_row_q, q_row_d;
  logic       moved_q, moved_d;
  logic       bumped_q, bumped_d;
  logic       goal_q, goal_d;
  logic [3:0] gstate_q;

  logic              active;
  logic              enter;
  logic              btn_any;
  logic [1:0]        dir_sel;
  logic signed [6:0] px_s, py_s, cx_s, cy_s;
  logic              oob;

  // Leading-edge cell k of the footprint for a given direction.
  function automatic logic [11:0] probe_at(input logic [1:0] d, input logic [1:0] k,
                                           input logic [5:0] x, input logic [5:0] y);
    logic [5:0] c;
    logic [5:0] r;
    case (d)
      D_UP:    begin c = x + {4'b0, k};  r = y - 6'd1;       end
      D_DOWN:  begin c = x + {4'b0, k};  r = y + 6'(P_SIZE); end
      D_LEFT:  begin c = x - 6'd1;       r = y + {4'b0, k};  end
      default: begin c = x + 6'(P_SIZE); r = y + {4'b0, k};  end
    endcase
    return {c, r};
  endfunction

  // Direction priority and signed candidate position with bounds check.
  always_comb begin
    active  = (state == 4'd2) || (state == 4'd4) || (state == 4'd6);
    enter   = active && (state != gstate_q);
    btn_any = btn_up | btn_down | btn_left | btn_right;
    if (btn_up)        dir_sel = D_UP;
    else if (btn_down) dir_sel = D_DOWN;
    else if (btn_left) dir_sel = D_LEFT;
    else               dir_sel = D_RIGHT;
    px_s = signed'({1'b0, px_q});
    py_s = signed'({1'b0, py_q});
    cx_s = px_s;
    cy_s = py_s;
    case (dir_sel)
      D_UP:    cy_s = py_s - 7'sd1;
      D_DOWN:  cy_s = py_s + 7'sd1;
      D_LEFT:  cx_s = px_s - 7'sd1;
      default: cx_s = px_s + 7'sd1;
    endcase
    oob = (cx_s < 7'sd0) || (cx_s > POS_MAX) || (cy_s < 7'sd0) || (cy_s > POS_MAX);
  end

  // Next-state logic for the move sequencer.
  always_comb begin
    fsm_d     = fsm_q;
    dir_d     = dir_q;
    k_d       = k_q;
    blocked_d = blocked_q;
    cand_x_d  = cand_x_q;
    cand_y_d  = cand_y_q;
    px_d      = px_q;
    py_d      = py_q;
    q_col_d   = q_col_q;
    q_row_d   = q_row_q;
    moved_d   = 1'b0;
    bumped_d  = 1'b0;
    goal_d    = 1'b0;
    if (enter) begin
      fsm_d = S_IDLE;
      px_d  = 6'(START_X);
      py_d  = 6'(START_Y);
    end else if (!active) begin
      fsm_d = S_IDLE;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (move_tick && btn_any) begin
            dir_d    = dir_sel;
            cand_x_d = cx_s[5:0];
            cand_y_d = cy_s[5:0];
            k_d      = 2'd0;
            if (oob) begin
              blocked_d = 1'b1;
              fsm_d     = S_COMMIT;
            end else begin
              blocked_d          = 1'b0;
              fsm_d              = S_CHECK;
              {q_col_d, q_row_d} = probe_at(dir_sel, 2'd0, px_q, py_q);
            end
          end
        end
        S_CHECK: begin
          if (wall_hit) begin
            blocked_d = 1'b1;
            fsm_d     = S_COMMIT;
          end else if (k_q == K_LAST) begin
            blocked_d = 1'b0;
            fsm_d     = S_COMMIT;
          end else begin
            k_d                = k_q + 2'd1;
            {q_col_d, q_row_d} = probe_at(dir_q, k_q + 2'd1, px_q, py_q);
          end
        end
        S_COMMIT: begin
          fsm_d = S_IDLE;
          if (!blocked_q) begin
            px_d    = cand_x_q;
            py_d    = cand_y_q;
            moved_d = 1'b1;
            goal_d  = (cand_x_q == 6'(GOAL_X)) && (cand_y_q == 6'(GOAL_Y));
          end else begin
            bumped_d = 1'b1;
          end
        end
        default: fsm_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      dir_q     <= D_UP;
      k_q       <= 2'd0;
      blocked_q <= 1'b0;
      cand_x_q  <= 6'd0;
      cand_y_q  <= 6'd0;
      px_q      <= 6'(START_X);
      py_q      <= 6'(START_Y);
      q_col_q   <= 6'd0;
      q_row_q   <= 6'd0;
      moved_q   <= 1'b0;
      bumped_q  <= 1'b0;
      goal_q    <= 1'b0;
      gstate_q  <= 4'd0;
    end else begin
      fsm_q     <= fsm_d;
      dir_q     <= dir_d;
      k_q       <= k_d;
      blocked_q <= blocked_d;
      cand_x_q  <= cand_x_d;
      cand_y_q  <= cand_y_d;
      px_q      <= px_d;
      py_q      <= py_d;
      q_col_q   <= q_col_d;
      q_row_q   <= q_row_d;
      moved_q   <= moved_d;
      bumped_q  <= bumped_d;
      goal_q    <= goal_d;
      gstate_q  <= state;
    end
  end

  assign q_en     = (fsm_q == S_CHECK);
  assign q_col    = q_col_q;
  assign q_row    = q_row_q;
  assign player_x = px_q;
  assign player_y = py_q;
  assign busy     = (fsm_q != S_IDLE);
  assign moved    = moved_q;
  assign bumped   = bumped_q;
  assign goal     = goal_q;

endmodule

// File: doc/player_move_ctrl.md
# player_move_ctrl

Sequences player movement through the wall-map lookup for the maze stages. On each movement tick it reads the requested direction and probes the leading edge of the 4×4-cell player footprint against the 40×40 wall map, one cell per cycle. It then commits or rejects the move. It owns the player's cell position that the renderer and stage FSM consume, and it is the only requester of the map lookup port.

## Interface

Parameters:
- MAP_W, 40: map side length in cells.
- P_SIZE, 4: player footprint side length in cells (fixed 4; probe count equals P_SIZE).
- START_X, 1: start column.
- START_Y, 1: start row.
- GOAL_X, 35: goal column.
- GOAL_Y, 17: goal row.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- state  in  4  game state; active stages are 2, 4 and 6 (STAGE1/2/3).
- move_tick  in  1  one-cycle movement strobe from the frame divider.
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced direction levels.
- q_en  out  1  map query valid.
- q_col  out  6  queried cell column.
- q_row  out  6  queried cell row.
- wall_hit  in  1  combinational map answer for (q_col, q_row), same cycle.
- player_x  out  6  player top-left column.
- player_y  out  6  player top-left row.
- busy  out  1  move in progress (CHECK or COMMIT).
- moved  out  1  one-cycle pulse: move committed.
- bumped  out  1  one-cycle pulse: move rejected.
- goal  out  1  one-cycle pulse: committed move landed on (GOAL_X, GOAL_Y).

## Operation

- FSM states: IDLE, CHECK, COMMIT.
- Active means `state` ∈ {2, 4, 6}. When `state` changes from any value to an active value, position loads (START_X, START_Y) on that edge and the FSM goes to IDLE.
- IDLE: when active, move_tick=1 and any button is high, latch the direction.
  - Priority is up > down > left > right.
  - Candidate position: up y-1, down y+1, left x-1, right x+1.
  - If the candidate is outside 0..MAP_W-P_SIZE (0..36), go to COMMIT with blocked=1. No probing.
  - Otherwise set probe index k=0 and go to CHECK.
- move_tick with no button: ignored. move_tick while busy: ignored, not queued.
- CHECK: q_en=1, with q_col/q_row driven from registers:
  - up (x+k, y-1)
  - down (x+k, y+4)
  - left (x-1, y+k)
  - right (x+4, y+k)
- wall_hit is sampled each CHECK cycle.
  - hit: go to COMMIT with blocked=1 (early abort).
  - no hit and k=3: go to COMMIT with blocked=0.
  - otherwise k+1.
- COMMIT: if blocked=0, update player_x/player_y to the candidate and pulse moved. If blocked=1, position is held and bumped pulses. goal pulses with moved when the new position equals (GOAL_X, GOAL_Y). Then return to IDLE.
- If `state` leaves the active set during CHECK or COMMIT, return to IDLE at the next edge with no position update and no pulses.
- Width rule: candidate arithmetic is 7-bit signed so x-1 at x=0 is detected as out of bounds, not wrapped.

## Timing

- Reset values: player_x=START_X, player_y=START_Y, q_en=0, q_col=0, q_row=0, busy=0, moved=0, bumped=0, goal=0. FSM resets to IDLE.
- Edges are counted from the one ending the tick cycle (E1).
  - E1: IDLE→CHECK, k=0.
  - E2..E5: probes k=0..3.
  - E6: COMMIT ends. Position and pulses are visible after E6.
- Full move latency: 6 cycles, tick to new position.
- Abort on probe k gives pulse visible after edge E(k+3).
- Out-of-bounds gives bumped visible after E2.
- q_en is high exactly during CHECK cycles. q_col/q_row hold their last value when q_en=0.
- busy is high in CHECK and COMMIT. It is low in the cycle the pulses appear.
- All outputs are registered except q_en/q_col/q_row, which decode from registers only and have no path from inputs.

## Test plan

- Reset with state=2 and all-free map model: player (1,1), all pulses 0. Assert rst mid-CHECK: outputs return to reset values immediately.
- Free map, (1,1), btn_right plus tick: probes (5,1),(5,2),(5,3),(5,4) on consecutive cycles. Position becomes (2,1) after E6, and moved pulses once.
- Model wall at cell (5,3), right from (1,1): 3 probes, then bumped after E5. Position stays (1,1) and moved stays 0.
- Position (36,10), btn_right plus tick: no q_en. bumped after E2, position unchanged. Repeat at (0,10) with btn_left.
- btn_up and btn_right together from (5,5): up is chosen, probes row 4, new position (5,4). A tick during busy produces no second move.
- Position (34,17), right: moved and goal pulse together, position (35,17). Switch state 2→3 mid-CHECK: no pulses. Switch 3→4: position reloads (1,1).
